// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage.
// Data path: 2-flop synchroniser, mid-bit sampling FSM, FWFT receive FIFO,
// valid/ready drain port. Framing errors and overruns are one-cycle pulses.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // Synchroniser and edge-history flops.
  logic rx_meta_q, rx_s_q, rx_prev_q;

  // Receive FSM state.
  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_good, stop_bad;

  // FIFO state.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          frame_err_q, overrun_q;
  logic          full, push, pop, drop;

  // Bring the asynchronous pin into the clock domain; idle-high reset values.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and simulation matches the synthesised netlist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // FSM state register with bit timing counters and the shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: start detection, mid-bit sampling, stop-bit verdict.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_cnt_q == CNT_HALF) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
          stop_good = rx_s_q;
          stop_bad  = !rx_s_q;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full = (count_q == CNT_FULL);
  assign pop  = rx_valid && rx_ready;
  assign push = stop_good && (!full || pop);
  assign drop = stop_good && full && !pop;

  // FIFO storage, pointers, occupancy and the registered status pulses.
  // NOTE: storage is reset because rx_data must read 0 after reset; this
  // keeps the array in flops rather than letting it map to a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shift_d;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW + 1)'(1);
        2'b01:   count_q <= count_q - (PW + 1)'(1);
        default: count_q <= count_q;
      endcase
      frame_err_q <= stop_bad;
      overrun_q   <= drop;
    end
  end

  assign rx_valid  = (count_q != '0);
  assign rx_data   = mem_q[rd_ptr_q];
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver with CLKS_PER_BIT=8,
// FIFO_DEPTH=4. Inputs change 1 ns after a rising edge; outputs are read there.
module tb_uart_receiver;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int   total  = 0;
  int   bad    = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  logic pre_valid;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // Count the number of cycles each status pulse is high.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    tick(n);
  endtask

  // Drives one 8N1 frame. Returns 1 ns after the edge that follows the stop
  // sample, i.e. in the cycle where the byte / status pulse first shows.
  // pre_valid holds rx_valid as seen during the stop-sample cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic ready_at_stop);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB - 2);
    pre_valid = rx_valid;
    if (ready_at_stop) rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, rx_valid, 1'b1);
    check({tag, "_data"}, rx_data, exp);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    // Reset state.
    rst      = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    idle(10);

    // Single byte, delivered the cycle after the stop sample.
    send_frame(8'hA5, 1'b1, 1'b0);
    check("single_pre_valid", pre_valid, 1'b0);
    check("single_valid", rx_valid, 1'b1);
    check("single_data", rx_data, 8'hA5);
    check("single_ferr", frame_err, 1'b0);
    idle(5);
    check("single_hold", rx_data, 8'hA5);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("single_popped", rx_valid, 1'b0);
    rx_ready = 1'b1;
    tick(3);
    rx_ready = 1'b0;
    check("ready_empty", rx_valid, 1'b0);

    // Glitch shorter than half a bit.
    uart_rx = 1'b0;
    tick(2);
    idle(30);
    check("glitch_valid", rx_valid, 1'b0);
    check("glitch_fe_cnt", fe_cnt, 0);
    check("glitch_ov_cnt", ov_cnt, 0);

    // Framing error followed by a good frame.
    send_frame(8'h3C, 1'b0, 1'b0);
    check("ferr_pulse", frame_err, 1'b1);
    check("ferr_valid", rx_valid, 1'b0);
    idle(4);
    check("ferr_cnt", fe_cnt, 1);
    check("ferr_low", frame_err, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    idle(2);
    pop_expect("after_ferr", 8'h11);
    check("after_ferr_empty", rx_valid, 1'b0);

    // Overrun: five back-to-back bytes into a four-entry FIFO.
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      idle(1);
    end
    send_frame(8'h05, 1'b1, 1'b0);
    check("ovr_pulse", overrun, 1'b1);
    idle(2);
    check("ovr_cnt", ov_cnt, 1);
    pop_expect("ovr_d1", 8'h01);
    pop_expect("ovr_d2", 8'h02);
    pop_expect("ovr_d3", 8'h03);
    pop_expect("ovr_d4", 8'h04);
    check("ovr_empty", rx_valid, 1'b0);

    // Push while full with a simultaneous pop.
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h21 + 8'(i), 1'b1, 1'b0);
      idle(1);
    end
    send_frame(8'h77, 1'b1, 1'b1);
    check("pf_no_ovr", overrun, 1'b0);
    idle(2);
    check("pf_ov_cnt", ov_cnt, 1);
    check("pf_count", dut.count_q, 4);
    pop_expect("pf_d1", 8'h22);
    pop_expect("pf_d2", 8'h23);
    pop_expect("pf_d3", 8'h24);
    pop_expect("pf_d4", 8'h77);
    check("pf_empty", rx_valid, 1'b0);

    // Asynchronous reset during data bit 3 with two bytes queued.
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(1);
    send_frame(8'h6B, 1'b1, 1'b0);
    idle(1);
    check("mr_queued", rx_valid, 1'b1);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'b1;
      tick(CPB);
    end
    uart_rx = 1'b0;
    tick(4);
    #3 rst = 1'b1;
    #1;
    check("mr_valid", rx_valid, 1'b0);
    check("mr_data", rx_data, 8'h00);
    uart_rx = 1'b1;
    tick(3);
    rst = 1'b0;
    idle(120);
    check("mr_no_byte", rx_valid, 1'b0);
    check("mr_fe_cnt", fe_cnt, 1);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(1);
    pop_expect("mr_fresh", 8'hC3);
    check("mr_final_empty", rx_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage that sits directly upstream of the SoC's peripheral bus. It consumes the raw `uart_rx` pin (8N1, LSB first, idle high) and synchronises and mid-bit samples it. Received bytes are buffered in a small first-word-fall-through FIFO, which the core drains through a valid/ready handshake. It reports framing errors and FIFO overruns as single-cycle pulses.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per bit; must be ≥ 4 (104 gives 115200 baud at 12 MHz).
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `uart_rx`  in  1  serial input; asynchronous to `clk`; idle high.
- `rx_data`  out  8  head-of-FIFO byte; valid only while `rx_valid` is high.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts the head byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.

## Operation

- **Synchroniser.** `uart_rx` passes through a 2-flop synchroniser (both flops reset to 1), giving `rx_s`. `rx_s` also feeds a one-flop history register (reset 1) used for falling-edge detection.
- **FSM states:** IDLE, START, DATA, STOP. Reset state is IDLE.
- **Counters.** `bit_cnt` counts 0..CLKS_PER_BIT-1. `bit_idx` counts 0..7.
- **IDLE.**
  - Leaves IDLE only on a falling edge of `rx_s` (previous value 1, current value 0); goes to START with `bit_cnt` = 0.
  - A line that is held low does not re-trigger.
- **START.**
  - Waits until `bit_cnt` = H-1, where H = floor(CLKS_PER_BIT/2), then samples `rx_s`.
  - If the sample is 0: go to DATA; clear `bit_cnt` and `bit_idx`.
  - If the sample is 1: treat it as a glitch and return to IDLE; nothing is reported.
- **DATA.**
  - At `bit_cnt` = CLKS_PER_BIT-1, shift `rx_s` into bit `bit_idx` of the shift register (LSB first), then increment `bit_idx`.
  - After bit 7 is sampled, go to STOP.
- **STOP.** At `bit_cnt` = CLKS_PER_BIT-1, sample `rx_s`, then always return to IDLE.
  - Stop sample = 1 and FIFO accepts: push the byte.
  - Stop sample = 1 and FIFO refuses: the byte is dropped and `overrun` pulses.
  - Stop sample = 0: pulse `frame_err` and drop the byte.
- **FIFO.**
  - Circular buffer with read/write pointers of width log2(FIFO_DEPTH) that wrap modulo FIFO_DEPTH, plus an occupancy count of width log2(FIFO_DEPTH)+1.
  - `rx_valid` = (count ≠ 0).
  - `rx_data` = entry at the read pointer, driven combinationally from storage.
  - Pop occurs when `rx_valid && rx_ready`. `rx_ready` while empty is ignored.
  - Push with full FIFO and simultaneous pop: both occur, the byte is accepted, there is no overrun, and the count stays at FIFO_DEPTH.
  - Push while empty: the byte becomes visible the next cycle. There is no same-cycle bypass.
- **Reset values** (asserted at any time, including mid-frame):
  - FSM returns to IDLE.
  - Pointers, count and the shift register are cleared.
  - `rx_valid` = 0, `rx_data` = 0 (storage cleared), `frame_err` = 0, `overrun` = 0.
  - Synchroniser flops = 1, so releasing reset while the line is low does not fake a start bit.

## Timing

- **Input latency.** The pin reaches `rx_s` 2 cycles after it changes. Let t0 be the cycle in which the falling edge of `rx_s` is detected.
- **Sample points:**
  - Start sample at t0+H.
  - Data bit i (0..7) sampled at t0+H+(i+1)·CLKS_PER_BIT.
  - Stop sample at t0+H+9·CLKS_PER_BIT.
- **Byte delivery.** On the cycle after the stop sample:
  - `rx_valid` rises (if the FIFO was empty), or `frame_err`/`overrun` is high for exactly that one cycle.
- **Back-to-back frames.** IDLE is re-entered before the end of the stop bit, so a start bit immediately following a stop bit is caught.
- **Baud tolerance.** Each bit is sampled at its midpoint, giving a nominal ±H cycles of margin.
- **Handshake.**
  - `rx_data` and `rx_valid` are stable until popped.
  - A pop advances the head on the next clock edge.
  - With `rx_ready` held high, one byte is consumed per cycle.

## Test plan

- **Single byte.** CLKS_PER_BIT=8, drive 0xA5 as 8N1 with `rx_ready`=0 → `rx_valid`=1 and `rx_data`=0xA5 on the cycle after the stop sample; a one-cycle `rx_ready` pulse → `rx_valid`=0.
- **Glitch rejection.** Low pulse of 2 cycles (< H=4) on `uart_rx` → FSM returns to IDLE; `rx_valid`, `frame_err` and `overrun` all stay 0.
- **Framing error.** Send 0x3C with the stop bit driven low → exactly one `frame_err` pulse; FIFO stays empty. A following valid frame 0x11 is received correctly.
- **Overrun.** FIFO_DEPTH=4, `rx_ready`=0, send 0x01..0x05 → one `overrun` pulse after the fifth stop sample. Draining then yields 0x01, 0x02, 0x03, 0x04, and `rx_valid` falls after the fourth pop.
- **Push while full.** FIFO full, assert `rx_ready` in the exact cycle a new byte 0x77 is pushed → no `overrun`; count remains 4; the drain order ends with 0x77; pointer wrap-around is exercised.
- **Mid-frame reset.** Assert `rst` asynchronously during DATA bit 3 of a frame, with 2 bytes already queued → outputs go to 0 immediately; after release there is no spurious byte, and a fresh frame 0xC3 is received correctly.
